// File: rtl/divider_pkg.sv
// divider_pkg
// Shared widths, counter width and FSM state type for the sequential
// restoring divider (seq_restoring_divider and its div_step datapath).
// No ports; imported with "import divider_pkg::*;".
package divider_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   // Counter walks DIVIDEND_W-1 down to 0, one restoring step per value.
   localparam int CNT_W      = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } divState_t;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor when the shifted value
// is not smaller than it, and report the resulting quotient bit.
// Ports:
//   remIn       partial remainder before this step (DIVISOR_W+1 bits)
//   dividendBit next dividend bit, MSB first
//   divisor     divisor operand
//   remOut      partial remainder after this step
//   quotBit     quotient bit produced by this step
module div_step
   import divider_pkg::*;
(
   input  logic [DIVISOR_W:0]   remIn,
   input  logic                 dividendBit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   remOut,
   output logic                 quotBit
);

   logic [DIVISOR_W:0]   shifted;
   logic [DIVISOR_W+1:0] diff;

   // Shift, trial-subtract and restore; remIn[MSB] is the bit shifted out
   // of the 9-bit window, which alone guarantees the subtraction succeeds.
   always_comb begin
      shifted = {remIn[DIVISOR_W-1:0], dividendBit};
      diff    = {1'b0, shifted} - {2'b00, divisor};
      quotBit = remIn[DIVISOR_W] | ~diff[DIVISOR_W+1];
      if (quotBit) begin
         remOut = diff[DIVISOR_W:0];
      end else begin
         remOut = shifted;
      end
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
// Sequential unsigned restoring divider, 16-bit dividend by 8-bit divisor,
// one quotient bit per clock (MSB first) with a valid/ready handshake on
// both the operand and the result side.
// Ports:
//   clk, n_rst              clock; asynchronous active-low reset
//   inValid/inReady         operand handshake (inReady high only in IDLE)
//   Dividend, Divisor       operands, captured on accept
//   outValid/outReady       result handshake (outValid high only in DONE)
//   Quotient, Remainder     result, held stable while in DONE
//   divByZero               result came from a zero divisor
// Build option: define DIV_EARLY_EXIT_EN to finish in one cycle when the
// divisor is nonzero and Dividend < Divisor (Q=0, R=Dividend).
module seq_restoring_divider
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [DIVIDEND_W-1:0] Dividend,
   input  logic [DIVISOR_W-1:0]  Divisor,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [DIVIDEND_W-1:0] Quotient,
   output logic [DIVISOR_W-1:0]  Remainder,
   output logic                  divByZero
);

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIVIDEND_W - 1);
   localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [DIVIDEND_W-1:0] QUOT_ZERO = {DIVIDEND_W{1'b0}};
   localparam logic [DIVIDEND_W-1:0] QUOT_ONES = {DIVIDEND_W{1'b1}};
   localparam logic [DIVISOR_W-1:0]  DSR_ZERO  = {DIVISOR_W{1'b0}};
   localparam logic [DIVISOR_W:0]    PREM_ZERO = {(DIVISOR_W + 1){1'b0}};

   divState_t             state,      stateNext;
   logic [CNT_W-1:0]      cnt,        cntNext;
   // Dividend shifts out MSB first while quotient bits fill in from the LSB.
   logic [DIVIDEND_W-1:0] work,       workNext;
   logic [DIVISOR_W-1:0]  divisorReg, divisorNext;
   logic [DIVISOR_W:0]    partRem,    partRemNext;
   logic [DIVIDEND_W-1:0] quotNext;
   logic [DIVISOR_W-1:0]  remNext;
   logic                  dbzNext;

   logic [DIVISOR_W:0]    stepRem;
   logic                  stepQuotBit;

   div_step uStep (
      .remIn       (partRem),
      .dividendBit (work[DIVIDEND_W-1]),
      .divisor     (divisorReg),
      .remOut      (stepRem),
      .quotBit     (stepQuotBit)
   );

   // Next-state and next-datapath decode; every register holds by default.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      workNext    = work;
      divisorNext = divisorReg;
      partRemNext = partRem;
      quotNext    = Quotient;
      remNext     = Remainder;
      dbzNext     = divByZero;
      case (state)
         IDLE: begin
            if (inValid) begin
               workNext    = Dividend;
               divisorNext = Divisor;
               partRemNext = PREM_ZERO;
               cntNext     = CNT_LAST;
               if (Divisor == DSR_ZERO) begin
                  stateNext = DONE;
                  quotNext  = QUOT_ONES;
                  remNext   = DSR_ZERO;
                  dbzNext   = 1'b1;
               end
`ifdef DIV_EARLY_EXIT_EN
               else if (Dividend < {{(DIVIDEND_W - DIVISOR_W){1'b0}}, Divisor}) begin
                  stateNext = DONE;
                  quotNext  = QUOT_ZERO;
                  remNext   = Dividend[DIVISOR_W-1:0];
                  dbzNext   = 1'b0;
               end
`endif
               else begin
                  stateNext = CALC;
               end
            end else begin
               stateNext = IDLE;
            end
         end
         CALC: begin
            workNext    = {work[DIVIDEND_W-2:0], stepQuotBit};
            partRemNext = stepRem;
            if (cnt == CNT_ZERO) begin
               stateNext = DONE;
               quotNext  = {work[DIVIDEND_W-2:0], stepQuotBit};
               remNext   = stepRem[DIVISOR_W-1:0];
               dbzNext   = 1'b0;
            end else begin
               cntNext = cnt - {{(CNT_W - 1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            // Leaving DONE only returns to IDLE; acceptance needs a fresh cycle.
            if (outReady) begin
               stateNext = IDLE;
            end else begin
               stateNext = DONE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake/result outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         cnt        <= CNT_ZERO;
         work       <= QUOT_ZERO;
         divisorReg <= DSR_ZERO;
         partRem    <= PREM_ZERO;
         Quotient   <= QUOT_ZERO;
         Remainder  <= DSR_ZERO;
         divByZero  <= 1'b0;
         inReady    <= 1'b1;
         outValid   <= 1'b0;
      end else begin
         state      <= stateNext;
         cnt        <= cntNext;
         work       <= workNext;
         divisorReg <= divisorNext;
         partRem    <= partRemNext;
         Quotient   <= quotNext;
         Remainder  <= remNext;
         divByZero  <= dbzNext;
         inReady    <= (stateNext == IDLE);
         outValid   <= (stateNext == DONE);
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table,
// hand-written hold/reset sequences and randomized operands checked
// against an arithmetic reference model.
module tb_seq_restoring_divider;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        inValid;
   logic        inReady;
   logic [15:0] Dividend;
   logic [7:0]  Divisor;
   logic        outValid;
   logic        outReady;
   logic [15:0] Quotient;
   logic [7:0]  Remainder;
   logic        divByZero;

   int checks = 0;
   int passes = 0;

   seq_restoring_divider dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .inValid   (inValid),
      .inReady   (inReady),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .outValid  (outValid),
      .outReady  (outReady),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Edges from the accept edge (counted as 1) until outValid is seen.
   function automatic int expLatency(input logic [15:0] a, input logic [7:0] b);
      if (b == 8'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
      if ({8'd0, b} > a) return 1;
`endif
      return 17;
   endfunction

   function automatic void refDiv(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r, output logic z);
      if (b == 8'd0) begin
         q = 16'hFFFF; r = 8'd0; z = 1'b1;
      end else begin
         q = a / {8'd0, b};
         r = 8'(a % {8'd0, b});
         z = 1'b0;
      end
   endfunction

   // Called at a negedge; presents operands, scrambles them after accept.
   task automatic startAndWait(input logic [15:0] a, input logic [7:0] b,
                               output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 50 && !inReady; i++) @(negedge clk);
      inValid  = 1'b1;
      Dividend = a;
      Divisor  = b;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         inValid  = 1'b0;
         Dividend = 16'($urandom);
         Divisor  = 8'($urandom);
         if (outValid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Consume the result while offering new operands; they must be ignored.
   task automatic consume(input string name);
      outReady = 1'b1;
      inValid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady = 1'b0;
      inValid  = 1'b0;
      check({name, "_idle_after_consume"}, 32'(inReady), 32'd1);
      check({name, "_no_valid_after_consume"}, 32'(outValid), 32'd0);
   endtask

   task automatic runOp(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r, input logic z);
      int lat;
      bit ok;
      startAndWait(a, b, lat, ok);
      check({name, "_completed"}, 32'(ok), 32'd1);
      check({name, "_latency"}, 32'(lat), 32'(expLatency(a, b)));
      check({name, "_quotient"}, 32'(Quotient), 32'(q));
      check({name, "_remainder"}, 32'(Remainder), 32'(r));
      check({name, "_divbyzero"}, 32'(divByZero), 32'(z));
      consume(name);
   endtask

   vec_t vecs[8];

   initial begin
      logic [15:0] ra, eq;
      logic [7:0]  rb, er;
      logic        ez;
      int          lat;
      bit          ok;

      vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0};
      vecs[1] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0};
      vecs[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0};
      vecs[3] = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,  1'b1};
      vecs[4] = '{16'd5,     8'd9,   16'd0,     8'd5,  1'b0};
      vecs[5] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0};
      vecs[6] = '{16'd40000, 8'd123, 16'd325,   8'd25, 1'b0};
      vecs[7] = '{16'd255,   8'd255, 16'd1,     8'd0,  1'b0};

      n_rst    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      Dividend = 16'd0;
      Divisor  = 8'd0;
      #2 n_rst = 1'b0;
      #1;
      check("reset_inReady", 32'(inReady), 32'd1);
      check("reset_outValid", 32'(outValid), 32'd0);
      check("reset_quotient", 32'(Quotient), 32'd0);
      check("reset_remainder", 32'(Remainder), 32'd0);
      check("reset_divbyzero", 32'(divByZero), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
      end

      // Result held in DONE while the consumer stalls and inputs churn.
      startAndWait(16'd1000, 8'd7, lat, ok);
      check("hold_completed", 32'(ok), 32'd1);
      for (int i = 0; i < 10; i++) begin
         inValid  = ~inValid;
         Dividend = 16'($urandom);
         Divisor  = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("hold_quotient", 32'(Quotient), 32'd142);
         check("hold_remainder", 32'(Remainder), 32'd6);
         check("hold_divbyzero", 32'(divByZero), 32'd0);
         check("hold_outValid", 32'(outValid), 32'd1);
         check("hold_inReady", 32'(inReady), 32'd0);
      end
      inValid = 1'b0;
      consume("hold");

      // Reset in the middle of a calculation discards it.
      inValid  = 1'b1;
      Dividend = 16'd40000;
      Divisor  = 8'd123;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("midcalc_busy", 32'(inReady), 32'd0);
      n_rst = 1'b0;
      #1;
      check("midrst_inReady", 32'(inReady), 32'd1);
      check("midrst_outValid", 32'(outValid), 32'd0);
      check("midrst_quotient", 32'(Quotient), 32'd0);
      check("midrst_remainder", 32'(Remainder), 32'd0);
      check("midrst_divbyzero", 32'(divByZero), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (20) @(negedge clk);
      check("postrst_idle", 32'(inReady), 32'd1);
      check("postrst_no_result", 32'(outValid), 32'd0);
      runOp("after_reset", 16'd40000, 8'd123, 16'd325, 8'd25, 1'b0);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         refDiv(ra, rb, eq, er, ez);
         runOp($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, eq, er, ez);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from divider_pkg (DIVIDEND_W=16, DIVISOR_W=8).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 n_rst  input  1  reset, asynchronous and active-low.
REQ-004 inValid  input  1  operand pair valid.
REQ-005 inReady  output  1  block can accept operands.
REQ-006 Dividend  input  16  unsigned dividend.
REQ-007 Divisor  input  8  unsigned divisor.
REQ-008 outValid  output  1  result valid, held until consumed.
REQ-009 outReady  input  1  consumer accepts result.
REQ-010 Quotient  output  16  unsigned quotient.
REQ-011 Remainder  output  8  unsigned remainder.
REQ-012 divByZero  output  1  result came from a zero divisor.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 inReady SHALL be 1 only in IDLE; outValid SHALL be 1 only in DONE.
REQ-015 Accept: in IDLE with inValid=1, capture Dividend/Divisor and go to CALC with the bit counter at 15.
REQ-016 CALC: one restoring step per cycle, MSB first, using a 9-bit partial remainder: shift in the next dividend bit, subtract Divisor if the result is >= 0, and set the quotient bit.
REQ-017 After exactly 16 CALC cycles the FSM SHALL enter DONE, so outValid rises on the 17th rising edge after the accept edge.
REQ-018 Outputs SHALL satisfy Dividend == Quotient*Divisor + Remainder with Remainder < Divisor for every nonzero Divisor.
REQ-019 Divisor=0: go from the accept edge directly to DONE on the next edge with Quotient=16'hFFFF, Remainder=8'h00, divByZero=1.
REQ-020 DONE: Quotient, Remainder and divByZero SHALL be held stable while outReady=0.
REQ-021 DONE with outReady=1 SHALL return the FSM to IDLE; no new operands SHALL be accepted in that same cycle.
REQ-022 inValid SHALL be ignored in CALC and DONE, and the captured operands SHALL NOT change.
REQ-023 Dividend=0 SHALL take the full 16 cycles and yield Q=0, R=0 (unless the macro in REQ-026 is defined).

Reset
REQ-024 n_rst=0 SHALL immediately force IDLE, inReady=1, outValid=0, Quotient=0, Remainder=0, divByZero=0 and counter=0.
REQ-025 Reset asserted mid-CALC or in DONE SHALL discard the operation, with no partial result visible after release.

Configuration
REQ-026 With DIV_EARLY_EXIT_EN defined, an accepted pair with nonzero Divisor and Dividend < Divisor SHALL go straight to DONE on the next edge with Quotient=0, Remainder=Dividend[7:0], divByZero=0.
REQ-027 Without DIV_EARLY_EXIT_EN, every nonzero-divisor operation SHALL take the full 16 CALC cycles.

Structure
REQ-028 divider_pkg SHALL hold DIVIDEND_W, DIVISOR_W, the FSM state enum type and the counter width constant.
REQ-029 One combinational sub-module, div_step, SHALL perform a single shift/compare/subtract and return the next partial remainder plus the quotient bit.
REQ-030 seq_restoring_divider SHALL instantiate div_step once and hold all sequential state itself.

Verification
REQ-031 Apply 1000/7 with outReady=1 -> outValid exactly 17 edges after accept; Q=142, R=6, divByZero=0.
REQ-032 Apply 65535/1, then 65535/255 -> Q=65535, R=0; then Q=257, R=0.
REQ-033 Apply 1234/0 -> DONE one edge after accept; Q=16'hFFFF, R=0, divByZero=1.
REQ-034 Apply 5/9 -> with DIV_EARLY_EXIT_EN: Q=0, R=5 one edge after accept; without it: same values after 17 edges.
REQ-035 Hold outReady=0 for 10 cycles in DONE while toggling inValid and operands -> outputs stable, inReady=0; then outReady=1 -> IDLE.
REQ-036 Pulse n_rst low during CALC cycle 8 of 40000/123 -> outputs zero, IDLE; then apply 40000/123 -> Q=325, R=25.
